// File: rtl/alu_pkg.sv
// Shared ALU arbiter definitions: function codes,
// condition-code bit positions and output slot states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_fun_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters,
// the result consumer and the shared ALU arbiter.
interface alu_arbiter_if #(
  parameter int W = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_fun;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_fun;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_val;
  logic [2:0]   rsp_cc;

  modport master (
    output req0_valid, req0_fun,
    output req0_a, req0_b,
    output req1_valid, req1_fun,
    output req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id,
    input  rsp_val, rsp_cc
  );

  modport slave (
    input  req0_valid, req0_fun,
    input  req0_a, req0_b,
    input  req1_valid, req1_fun,
    input  req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id,
    output rsp_val, rsp_cc
  );

endinterface

// File: rtl/alu_arbiter_core.sv
// Combinational Y86 ALU: add/sub/and/xor with
// zero, sign and signed-overflow flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [1:0]   fun,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic [2:0]   cc
);

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic [W-1:0] land;
  logic [W-1:0] lxor;
  logic         is_add;
  logic         is_sub;
  logic         is_and;
  logic         of;

  assign sum  = a + b;
  assign diff = a - b;
  assign land = a & b;
  assign lxor = a ^ b;

  assign is_add = (fun == ALU_ADD);
  assign is_sub = (fun == ALU_SUB);
  assign is_and = (fun == ALU_AND);

  always_comb begin
    result = lxor;
    unique case (1'b1)
      is_add:  result = sum;
      is_sub:  result = diff;
      is_and:  result = land;
      default: result = lxor;
    endcase
  end

  // Overflow only for the arithmetic ops; sub flips
  // the operand sign agreement test.
  always_comb begin
    of = 1'b0;
    unique case (1'b1)
      is_add: of = (a[W-1] == b[W-1]) &&
                   (result[W-1] != a[W-1]);
      is_sub: of = (a[W-1] != b[W-1]) &&
                   (result[W-1] != a[W-1]);
      default: of = 1'b0;
    endcase
  end

  always_comb begin
    cc        = 3'b000;
    cc[CC_ZF] = (result == '0);
    cc[CC_SF] = result[W-1];
    cc[CC_OF] = of;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two
// requesters, with a single-entry registered result slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  slot_e        state;
  slot_e        state_nxt;
  logic         last_id;
  logic         can_accept;
  logic         gnt0;
  logic         gnt1;
  logic         grant;
  logic         sel;
  logic [1:0]   fun;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] res;
  logic [2:0]   cc;
  logic         id_q;
  logic [W-1:0] val_q;
  logic [2:0]   cc_q;

  assign can_accept = (state == SLOT_EMPTY) ||
                      bus.rsp_ready;

  // last_id==1 means req1 went last, so req0 wins ties.
  assign gnt0 = bus.req0_valid &&
                (!bus.req1_valid || last_id);
  assign gnt1 = bus.req1_valid &&
                (!bus.req0_valid || !last_id);

  assign bus.req0_ready = rst_n && can_accept && gnt0;
  assign bus.req1_ready = rst_n && can_accept && gnt1;

  assign grant = bus.req0_ready || bus.req1_ready;
  assign sel   = bus.req1_ready;

  assign fun  = sel ? bus.req1_fun : bus.req0_fun;
  assign op_a = sel ? bus.req1_a   : bus.req0_a;
  assign op_b = sel ? bus.req1_b   : bus.req0_b;

  alu_core #(
    .W (W)
  ) u_core (
    .fun    (fun),
    .a      (op_a),
    .b      (op_b),
    .result (res),
    .cc     (cc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      SLOT_EMPTY: begin
        if (grant) state_nxt = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (bus.rsp_ready && !grant)
          state_nxt = SLOT_EMPTY;
      end
      default: state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
      id_q    <= 1'b0;
      val_q   <= '0;
      cc_q    <= 3'b000;
    end else if (grant) begin
      last_id <= sel;
      id_q    <= sel;
      val_q   <= res;
      cc_q    <= cc;
    end
  end

  assign bus.rsp_valid = (state == SLOT_FULL);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_val   = val_q;
  assign bus.rsp_cc    = cc_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter
// against a queue-free behavioural slot model.
module tb_alu_arbiter;

  localparam int W = 64;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.W(W)) bus ();

  alu_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          pv [2];
  logic [1:0]  pf [2];
  logic [63:0] pa [2];
  logic [63:0] pb [2];

  bit          m_full;
  int          m_id;
  int          m_last;
  logic [63:0] m_val;
  logic [2:0]  m_cc;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference ALU using a sign-extended wide sum:
  // overflow is when the result does not fit in W bits.
  task automatic ref_alu(input logic [1:0] f,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         output logic [63:0] r,
                         output logic [2:0] cc);
    logic signed [64:0] wa;
    logic signed [64:0] wb;
    logic signed [64:0] wide;
    bit of;
    wa = {a[63], a};
    wb = {b[63], b};
    of = 1'b0;
    if (f == 2'd0) begin
      wide = wa + wb;
      r = wide[63:0];
      of = (wide[64] != wide[63]);
    end else if (f == 2'd1) begin
      wide = wa - wb;
      r = wide[63:0];
      of = (wide[64] != wide[63]);
    end else if (f == 2'd2) begin
      r = a & b;
    end else begin
      r = a ^ b;
    end
    cc = {(r == 64'd0), r[63], of};
  endtask

  function automatic logic [63:0] rnd64();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic pend(input int n, input logic [1:0] f,
                      input logic [63:0] a,
                      input logic [63:0] b);
    pv[n] = 1'b1;
    pf[n] = f;
    pa[n] = a;
    pb[n] = b;
  endtask

  task automatic pend_rnd(input int n);
    pend(n, 2'($urandom_range(0, 3)), rnd64(), rnd64());
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_id   = 0;
    m_last = 1;
    m_val  = 64'd0;
    m_cc   = 3'd0;
    pv[0]  = 1'b0;
    pv[1]  = 1'b0;
  endtask

  task automatic drive();
    bus.req0_valid = pv[0];
    bus.req0_fun   = pf[0];
    bus.req0_a     = pa[0];
    bus.req0_b     = pb[0];
    bus.req1_valid = pv[1];
    bus.req1_fun   = pf[1];
    bus.req1_a     = pa[1];
    bus.req1_b     = pb[1];
  endtask

  // One clock: drive after negedge, compare, then
  // advance the model at the posedge.
  task automatic cycle(input bit rr, output int gid);
    bit e_can;
    bit e0;
    bit e1;
    logic [63:0] r;
    logic [2:0]  c;
    drive();
    bus.rsp_ready = rr;
    #1;
    e_can = !m_full || rr;
    e0 = e_can && pv[0] && (!pv[1] || m_last == 1);
    e1 = e_can && pv[1] && (!pv[0] || m_last == 0);
    chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
    chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
    if (m_full) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
      chk("rsp_val", bus.rsp_val, m_val);
      chk("rsp_cc", 64'(bus.rsp_cc), 64'(m_cc));
    end
    @(posedge clk);
    gid = e0 ? 0 : (e1 ? 1 : -1);
    if (gid >= 0) begin
      ref_alu(pf[gid], pa[gid], pb[gid], r, c);
      m_full  = 1'b1;
      m_id    = gid;
      m_val   = r;
      m_cc    = c;
      m_last  = gid;
      pv[gid] = 1'b0;
    end else if (rr) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input int id,
                     input logic [63:0] v,
                     input logic [2:0] c);
    #1;
    chk({nm, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    chk({nm, "_id"}, 64'(bus.rsp_id), 64'(id));
    chk({nm, "_val"}, bus.rsp_val, v);
    chk({nm, "_cc"}, 64'(bus.rsp_cc), 64'(c));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g;
  int g_first;
  logic [63:0] hold_val;

  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    model_reset();
    pend(0, 2'd0, 64'd5, 64'd6);
    pend(1, 2'd1, 64'd5, 64'd6);
    drive();
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_val", bus.rsp_val, 64'd0);
    chk("rst_cc", 64'(bus.rsp_cc), 64'd0);
    chk("rst_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rdy0", 64'(bus.req0_ready), 64'd0);
    chk("rst_rdy1", 64'(bus.req1_ready), 64'd0);
    do_reset();

    pend(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    cycle(1'b1, g);
    lit("add_ovf", 0, 64'h8000_0000_0000_0000, 3'b011);

    pend(1, 2'd1, 64'h8000_0000_0000_0000, 64'd1);
    cycle(1'b1, g);
    lit("sub_ovf", 1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001);

    pend(1, 2'd3, 64'h2D, 64'h2D);
    cycle(1'b1, g);
    lit("xor_zero", 1, 64'd0, 3'b100);
    cycle(1'b1, g);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (!pv[0] && i < 8) pend_rnd(0);
      if (!pv[1] && i < 8) pend_rnd(1);
      cycle(1'b1, g);
      chk("rr_order", 64'(g), 64'(i % 2));
      #1;
      chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
    end
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    cycle(1'b1, g);

    pend_rnd(0);
    pend_rnd(1);
    cycle(1'b1, g_first);
    if (!pv[0]) pend_rnd(0);
    if (!pv[1]) pend_rnd(1);
    #1;
    hold_val = bus.rsp_val;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, g);
      chk("stall_grant", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
      #1;
      chk("stall_frozen", bus.rsp_val, m_val);
    end
    cycle(1'b1, g);
    chk("release_grant", 64'(g), 64'(1 - g_first));
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    cycle(1'b1, g);
    cycle(1'b1, g);

    for (int i = 0; i < 2; i++) begin
      pend(0, 2'd2, 64'h2D, 64'h33);
      cycle(1'b1, g);
      lit("and_b2b", 0, 64'h21, 3'b000);
    end
    cycle(1'b1, g);

    pend(0, 2'd0, 64'd3, 64'd4);
    cycle(1'b0, g);
    cycle(1'b0, g);
    pend(1, 2'd0, 64'd1, 64'd1);
    drive();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_rdy1", 64'(bus.req1_ready), 64'd0);
    model_reset();
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, g);
    cycle(1'b1, g);

    for (int i = 0; i < 400; i++) begin
      if (!pv[0] && $urandom_range(0, 2) != 0) pend_rnd(0);
      if (!pv[1] && $urandom_range(0, 2) != 0) pend_rnd(1);
      cycle($urandom_range(0, 3) != 0, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and result register that shares one 64-bit Y86 ALU (add, sub, and, xor) between two requesters, such as the execute stage and an address/increment unit. It accepts at most one operation per cycle over valid/ready handshakes and computes it through a combinational ALU core. The result and condition codes (ZF, SF, OF) are registered into a single-entry output slot with its own valid/ready handshake.

## Interface
- `W`, default 64: operand/result width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle when valid&ready.
- `req0_fun`, `req1_fun`  in  2 each  00 add, 01 sub, 10 and, 11 xor.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  W each  operands.
- `rsp_valid`  out  1  output slot holds a result.
- `rsp_ready`  in  1  consumer takes the result when valid&ready.
- `rsp_id`  out  1  requester index of the held result.
- `rsp_val`  out  W  result.
- `rsp_cc`  out  3  {ZF, SF, OF}.

## Operation
- Slot state: EMPTY or FULL.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on rsp_ready with no grant.
  - FULL→FULL on rsp_ready with a grant (back-to-back).
- `can_accept = !rsp_valid || rsp_ready`.
- Grant rule:
  - Only one requester valid: it is granted when can_accept.
  - Both valid: grant the one not granted last (`last_id` pointer).
- `last_id` updates only on a grant.
- `reqN_ready = can_accept && granted(N)`. The non-granted ready is 0.
- A requester holds valid and operands stable until accepted; it never drops valid unaccepted.
- Arithmetic, modulo 2^W:
  - add: A+B.
  - sub: A−B.
  - and: A&B.
  - xor: A^B.
- Flags:
  - ZF = (result == 0).
  - SF = result[W-1].
- OF:
  - add: A[W-1]==B[W-1] && result[W-1]!=A[W-1].
  - sub: A[W-1]!=B[W-1] && result[W-1]!=A[W-1].
  - and/xor: 0.
- Result, flags and rsp_id are captured together on the grant edge. They are held unchanged while rsp_valid && !rsp_ready.

## Timing
- Latency: a request accepted at edge N produces rsp_valid=1 with its data after edge N. It is visible in cycle N+1.
- Throughput: one operation per cycle while rsp_ready=1.
- reqN_ready is combinational from reqN_valid, rsp_valid, rsp_ready and last_id. There is no path from operands to ready.
- Reset (rst_n=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_val=0, rsp_cc=0.
  - last_id=1, so req0 wins the first contention.
  - Both readies are 0 while rst_n=0.
- Reset mid-operation: a held result is discarded. No response is produced for it after rst_n rises.
- Simultaneous rsp_ready and a new grant: the old result is consumed and the new result is loaded on the same edge. rsp_valid stays 1.
- Output full with rsp_ready=0: both readies are 0 and requests wait. last_id is unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_AND`=2'b10, `ALU_XOR`=2'b11.
  - CC bit indices `CC_ZF`=2, `CC_SF`=1, `CC_OF`=0.
- Sub-module `alu_core`: combinational. Inputs fun, a, b; outputs result and cc. It muxes the existing gated add/sub/and/xor outputs and computes the flags.
- The arbiter holds the grant logic, the `last_id` flop and the output slot registers.

## Test plan
- Reset check: rst_n low → rsp_valid=0, rsp_val=0, rsp_cc=0. Assert rst_n mid-hold → rsp_valid drops asynchronously.
- req0 add A=2^63−1, B=1 → next cycle rsp_id=0, rsp_val=0x8000000000000000, cc={0,1,1}.
- req1 sub A=−2^63, B=1 → rsp_id=1, rsp_val=0x7FFFFFFFFFFFFFFF, cc={0,0,1}. Then xor A=B=0x2D → rsp_val=0, cc={1,0,0}.
- Both valid continuously, rsp_ready=1, four ops each → grant order 0,1,0,1,…. rsp_valid high every cycle after the first.
- rsp_ready=0 for 3 cycles with both valid → rsp_val/cc/id frozen, both readies 0. Release → the next grant goes to the requester not last granted.
- and A=0b101101, B=0b110011 back-to-back with rsp_ready=1 → rsp_val=0b100001, cc={0,0,0}. No bubble between consecutive results.
